// File: rtl/updown_counter_n_pkg.sv
// Shared types and helpers for the parametrised up/down counter.
// Optional prescaler feature macro: UPDOWN_CNT_PRESCALE_EN
package updown_cnt_pkg;

  typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT  = 1'b1} cnt_mode_t;
  typedef enum logic {CNT_UP   = 1'b0, CNT_DOWN = 1'b1} cnt_dir_t;

  // Wide enough for WIDTH+1 arithmetic at the largest supported WIDTH (16).
  localparam int unsigned CNT_ARITH_W = 17;

  // Out-of-range load values pin to the top of the count range; they never wrap.
  function automatic logic [CNT_ARITH_W-1:0] clamp_load(
    input logic [CNT_ARITH_W-1:0] val,
    input logic [CNT_ARITH_W-1:0] max_val
  );
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/updown_counter_n_if.sv
// Control/status bundle of the up/down counter.
// Optional prescaler feature macro: UPDOWN_CNT_PRESCALE_EN
interface updown_counter_n_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             down;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrapped;

  modport master (
    output en, down, sat, load, load_val,
    input  q, tc, wrapped
  );

  modport slave (
    input  en, down, sat, load, load_val,
    output q, tc, wrapped
  );
endinterface

// File: rtl/updown_counter_n_prescaler.sv
// Enable divider: counts enabled edges modulo PRESCALE and raises tick on the
// last phase so the counter steps once per PRESCALE enabled edges.
// Used only when UPDOWN_CNT_PRESCALE_EN is defined.
module updown_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LP_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  // tick is combinational so the counter steps on the same edge the phase rolls over
  assign tick = en && (r_cnt == LP_LAST);

  // Phase counter: clear wins, en=0 freezes the phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (r_cnt == LP_LAST) r_cnt <= '0;
      else                  r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with parallel load, count enable, wrap or
// saturate mode, terminal-count and wrap-event flags.
// Optional feature macro: UPDOWN_CNT_PRESCALE_EN (divides the count enable by PRESCALE).
module updown_counter_n
  import updown_cnt_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 4
) (
  input  logic               clk,
  input  logic               reset,
  updown_counter_n_if.slave  bus
);
  localparam logic [WIDTH:0]             LP_MAX   = (WIDTH+1)'(MODULUS - 1);
  localparam logic [CNT_ARITH_W-1:0]     LP_MAX_W = CNT_ARITH_W'(MODULUS - 1);

  // Count is held one bit wider than q so MODULUS == 2**WIDTH cannot overflow.
  logic [WIDTH:0] r_q;
  logic           r_wrapped;
  logic [WIDTH:0] w_next_q;
  logic           w_next_wrap;
  logic           w_step_en;
  logic [WIDTH:0] w_load_q;
  cnt_dir_t       w_dir;
  cnt_mode_t      w_mode;

  assign w_dir    = cnt_dir_t'(bus.down);
  assign w_mode   = cnt_mode_t'(bus.sat);
  assign w_load_q = (WIDTH+1)'(clamp_load(CNT_ARITH_W'(bus.load_val), LP_MAX_W));

`ifdef UPDOWN_CNT_PRESCALE_EN
  updown_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .clr   (bus.load),
    .tick  (w_step_en)
  );
`else
  assign w_step_en = bus.en;
`endif

  // Next-state selection: load beats count, count beats hold
  always_comb begin
    w_next_q    = r_q;
    w_next_wrap = 1'b0;
    if (bus.load) begin
      w_next_q = w_load_q;
    end else if (w_step_en) begin
      if (w_dir == CNT_UP) begin
        if (r_q == LP_MAX) begin
          if (w_mode == CNT_WRAP) begin
            w_next_q    = '0;
            w_next_wrap = 1'b1;
          end
        end else begin
          w_next_q = r_q + (WIDTH+1)'(1);
        end
      end else begin
        if (r_q == '0) begin
          if (w_mode == CNT_WRAP) begin
            w_next_q    = LP_MAX;
            w_next_wrap = 1'b1;
          end
        end else begin
          w_next_q = r_q - (WIDTH+1)'(1);
        end
      end
    end
  end

  // Count and wrap-pulse registers; wrapped lasts exactly one cycle per wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q       <= '0;
      r_wrapped <= 1'b0;
    end else begin
      r_q       <= w_next_q;
      r_wrapped <= w_next_wrap;
    end
  end

  assign bus.q       = r_q[WIDTH-1:0];
  assign bus.wrapped = r_wrapped;
  // Terminal count looks at the live direction, not the registered one
  assign bus.tc      = (w_dir == CNT_DOWN) ? (r_q == '0) : (r_q == LP_MAX);
endmodule

// File: tb/tb_updown_counter_n.sv
// Scoreboard bench for updown_counter_n (WIDTH=4, MODULUS=10, PRESCALE=4).
// Build with UPDOWN_CNT_PRESCALE_EN to exercise the prescaler sequence instead.
module tb_updown_counter_n;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  event chk_ev;

  typedef struct {
    string      nm;
    logic [3:0] q;
    logic       tc;
    logic       wr;
  } exp_t;

  exp_t sb[$];

  updown_counter_n_if #(.WIDTH(4)) ifc ();

  updown_counter_n #(
    .WIDTH    (4),
    .MODULUS  (10),
    .PRESCALE (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected terminal count for the q the DUT should present and the live direction
  function automatic logic exp_tc(input logic d, input logic [3:0] q);
    return d ? (q == 4'd0) : (q == 4'd9);
  endfunction

  // One clocked cycle: drive at negedge, expect the state after the next posedge
  task automatic cyc(input string nm, input logic r, input logic e, input logic d,
                     input logic s, input logic l, input logic [3:0] lv,
                     input logic [3:0] eq, input logic ew);
    exp_t x;
    @(negedge clk);
    reset        = r;
    ifc.en       = e;
    ifc.down     = d;
    ifc.sat      = s;
    ifc.load     = l;
    ifc.load_val = lv;
    x.nm = nm; x.q = eq; x.tc = exp_tc(d, eq); x.wr = ew;
    sb.push_back(x);
  endtask

  // Assert reset between clock edges and check the outputs without any edge
  task automatic rst_chk(input string nm, input logic d);
    exp_t x;
    @(negedge clk);
    #2;
    reset    = 1'b1;
    ifc.down = d;
    x.nm = nm; x.q = 4'd0; x.tc = d; x.wr = 1'b0;
    sb.push_back(x);
    -> chk_ev;
  endtask

  // Monitor: compares after every active edge, or on demand for async checks
  initial begin
    forever begin
      exp_t x;
      @(posedge clk or chk_ev);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        n_tests++;
        if (ifc.q !== x.q || ifc.tc !== x.tc || ifc.wrapped !== x.wr) begin
          n_fail++;
          $display("FAIL %s: got q=%0d tc=%0b wrapped=%0b, expected q=%0d tc=%0b wrapped=%0b",
                   x.nm, ifc.q, ifc.tc, ifc.wrapped, x.q, x.tc, x.wr);
        end
      end
    end
  end

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    reset        = 1'b1;
    ifc.en       = 1'b0;
    ifc.down     = 1'b0;
    ifc.sat      = 1'b0;
    ifc.load     = 1'b0;
    ifc.load_val = 4'd0;

    rst_chk("rst_init_up", 1'b0);
    rst_chk("rst_init_dn", 1'b1);
    cyc("rel_hold", 0, 0, 0, 0, 0, 4'd0, 4'd0, 0);

`ifdef UPDOWN_CNT_PRESCALE_EN
    cyc("pld", 0, 0, 0, 0, 1, 4'd0, 4'd0, 0);
    cyc("p1", 0, 1, 0, 0, 0, 4'd0, 4'd0, 0);
    cyc("p2", 0, 1, 0, 0, 0, 4'd0, 4'd0, 0);
    cyc("p3", 0, 1, 0, 0, 0, 4'd0, 4'd0, 0);
    cyc("p4", 0, 1, 0, 0, 0, 4'd0, 4'd1, 0);
    cyc("p5", 0, 1, 0, 0, 0, 4'd0, 4'd1, 0);
    cyc("p6", 0, 1, 0, 0, 0, 4'd0, 4'd1, 0);
    cyc("p7", 0, 1, 0, 0, 0, 4'd0, 4'd1, 0);
    cyc("p8", 0, 1, 0, 0, 0, 4'd0, 4'd2, 0);
    cyc("p9", 0, 1, 0, 0, 0, 4'd0, 4'd2, 0);
    cyc("pfrz1", 0, 0, 0, 0, 0, 4'd0, 4'd2, 0);
    cyc("pfrz2", 0, 0, 0, 0, 0, 4'd0, 4'd2, 0);
    cyc("pfrz3", 0, 0, 0, 0, 0, 4'd0, 4'd2, 0);
    cyc("p10", 0, 1, 0, 0, 0, 4'd0, 4'd2, 0);
    cyc("p11", 0, 1, 0, 0, 0, 4'd0, 4'd2, 0);
    cyc("p12", 0, 1, 0, 0, 0, 4'd0, 4'd3, 0);
`else
    // Wrap-mode up count over the full range and past the wrap
    cyc("up1", 0, 1, 0, 0, 0, 4'd0, 4'd1, 0);
    cyc("up2", 0, 1, 0, 0, 0, 4'd0, 4'd2, 0);
    cyc("up3", 0, 1, 0, 0, 0, 4'd0, 4'd3, 0);
    cyc("up4", 0, 1, 0, 0, 0, 4'd0, 4'd4, 0);
    cyc("up5", 0, 1, 0, 0, 0, 4'd0, 4'd5, 0);
    cyc("up6", 0, 1, 0, 0, 0, 4'd0, 4'd6, 0);
    cyc("up7", 0, 1, 0, 0, 0, 4'd0, 4'd7, 0);
    cyc("up8", 0, 1, 0, 0, 0, 4'd0, 4'd8, 0);
    cyc("up9", 0, 1, 0, 0, 0, 4'd0, 4'd9, 0);
    cyc("up_wrap", 0, 1, 0, 0, 0, 4'd0, 4'd0, 1);
    cyc("up_after1", 0, 1, 0, 0, 0, 4'd0, 4'd1, 0);
    cyc("up_after2", 0, 1, 0, 0, 0, 4'd0, 4'd2, 0);
    // Wrap-mode down count through zero
    cyc("ld0", 0, 0, 1, 0, 1, 4'd0, 4'd0, 0);
    cyc("dn_wrap", 0, 1, 1, 0, 0, 4'd0, 4'd9, 1);
    cyc("dn8", 0, 1, 1, 0, 0, 4'd0, 4'd8, 0);
    cyc("dn7", 0, 1, 1, 0, 0, 4'd0, 4'd7, 0);
    // Saturate at the top, then step down
    cyc("ld9_sat", 0, 0, 0, 1, 1, 4'd9, 4'd9, 0);
    cyc("sat_up1", 0, 1, 0, 1, 0, 4'd0, 4'd9, 0);
    cyc("sat_up2", 0, 1, 0, 1, 0, 4'd0, 4'd9, 0);
    cyc("sat_up3", 0, 1, 0, 1, 0, 4'd0, 4'd9, 0);
    cyc("sat_dn", 0, 1, 1, 1, 0, 4'd0, 4'd8, 0);
    // Saturate at zero
    cyc("ld0_sat", 0, 0, 1, 1, 1, 4'd0, 4'd0, 0);
    cyc("sat_dn0", 0, 1, 1, 1, 0, 4'd0, 4'd0, 0);
    // Load clamps, wins over count, and clears a pending wrap pulse
    cyc("wrap_again", 0, 1, 1, 0, 0, 4'd0, 4'd9, 1);
    cyc("ld13", 0, 1, 1, 0, 1, 4'd13, 4'd9, 0);
    cyc("ld6", 0, 0, 0, 0, 1, 4'd6, 4'd6, 0);
    cyc("hold6", 0, 0, 0, 0, 0, 4'd0, 4'd6, 0);
    // Asynchronous reset mid-count, held across an edge, then released
    rst_chk("rst_async", 1'b0);
    cyc("rst_held", 1, 1, 0, 0, 0, 4'd0, 4'd0, 0);
    cyc("rel_cnt", 0, 1, 0, 0, 0, 4'd0, 4'd1, 0);
`endif

    repeat (4) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
